// File: rtl/iob_fifo2stream.sv
// Read-side adapter: turns a FIFO read port (data one cycle after r_en) into a
// full-throughput valid/ready stream. Optional framing via IOB_FIFO2STREAM_LAST_EN.
module iob_fifo2stream #(
  parameter int DATA_W = 21,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic              fifo_r_en_o,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_r_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
`ifdef IOB_FIFO2STREAM_LAST_EN
  input  logic [LEN_W-1:0]  len_i,
  output logic              last_o,
`endif
  output logic [1:0]        level_o
);

  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic [1:0]        r_level;
  logic              r_pending;
  logic              w_pop;
  logic              w_rEn;
  logic [2:0]        w_occ;

  assign w_pop   = (r_level != 2'd0) & ready_i;
  // Words that will occupy the buffer after this edge, counting the in-flight read.
  assign w_occ   = {1'b0, r_level} + {2'b00, r_pending} - {2'b00, w_pop};
  assign w_rEn   = arst_n_i & en_i & ~fifo_empty_i & ~rst_i & (w_occ < 3'd2);

  assign fifo_r_en_o = w_rEn;
  assign valid_o     = (r_level != 2'd0);
  assign data_o      = r_buf0;
  assign level_o     = r_level;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_level   <= 2'd0;
      r_pending <= 1'b0;
    end else if (rst_i) begin
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_level   <= 2'd0;
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_rEn;
      case ({w_pop, r_pending})
        2'b11: begin
          if (r_level == 2'd1) begin
            r_buf0 <= fifo_r_data_i;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_r_data_i;
          end
        end
        2'b10: begin
          r_buf0  <= r_buf1;
          r_level <= r_level - 2'd1;
        end
        2'b01: begin
          if (r_level == 2'd0) begin
            r_buf0 <= fifo_r_data_i;
          end else begin
            r_buf1 <= fifo_r_data_i;
          end
          r_level <= r_level + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IOB_FIFO2STREAM_LAST_EN
  logic [LEN_W-1:0] r_wordCnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_lenRaw;
  logic [LEN_W-1:0] w_lenEff;
  logic             w_last;

  // The first word of a frame uses len_i live; later words use the sampled copy.
  assign w_lenRaw = (r_wordCnt == '0) ? len_i : r_len;
  assign w_lenEff = (w_lenRaw == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : w_lenRaw;
  assign w_last   = valid_o & (r_wordCnt == w_lenEff - {{(LEN_W-1){1'b0}}, 1'b1});
  assign last_o   = w_last;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wordCnt <= '0;
      r_len     <= '0;
    end else if (rst_i) begin
      r_wordCnt <= '0;
      r_len     <= '0;
    end else if (w_pop) begin
      if (r_wordCnt == '0) begin
        r_len <= len_i;
      end
      if (w_last) begin
        r_wordCnt <= '0;
      end else begin
        r_wordCnt <= r_wordCnt + {{(LEN_W-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule

// File: tb/tb_iob_fifo2stream.sv
// Self-checking bench for iob_fifo2stream: directed phases plus random stress,
// checked every cycle against a queue-based model of the FIFO and stream.
module tb_iob_fifo2stream;

  localparam int DATA_W = 21;
  localparam int LEN_W  = 16;

  logic              clk_i = 1'b0;
  logic              arst_n_i;
  logic              rst_i;
  logic              en_i;
  logic              fifo_r_en_o;
  logic              fifo_empty_i;
  logic [DATA_W-1:0] fifo_r_data_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        level_o;
`ifdef IOB_FIFO2STREAM_LAST_EN
  logic [LEN_W-1:0]  len_i;
  logic              last_o;
`endif

  iob_fifo2stream #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i         (clk_i),
    .arst_n_i      (arst_n_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .fifo_r_en_o   (fifo_r_en_o),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_r_data_i (fifo_r_data_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .data_o        (data_o),
`ifdef IOB_FIFO2STREAM_LAST_EN
    .len_i         (len_i),
    .last_o        (last_o),
`endif
    .level_o       (level_o)
  );

  always #5 clk_i = ~clk_i;

  int nChecks = 0;
  int nFails  = 0;

  logic [DATA_W-1:0] fifoQ[$];
  logic [DATA_W-1:0] outQ[$];
  logic [DATA_W-1:0] sentQ[$];
  logic [DATA_W-1:0] recvQ[$];
  logic              pend = 1'b0;
  logic [DATA_W-1:0] pendVal = '0;
  logic              forceEmpty = 1'b0;
  int                cycleNo = 0;
  int                popCycles[$];
  int                rEnCount = 0;
  int                lastCount = 0;
  int                frameIdx = 0;
  int                frameLen = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are already set; check at negedge, advance the model at posedge.
  task automatic stepCycle();
    int  expLevel;
    bit  pop;
    bit  expREn;
    bit  rEnSeen;
    fifo_empty_i = (fifoQ.size() == 0) || forceEmpty;
    @(negedge clk_i);
    expLevel = outQ.size();
    check("level", 32'(level_o), 32'(expLevel));
    check("valid", 32'(valid_o), 32'(expLevel != 0));
    if (expLevel != 0) check("data", 32'(data_o), 32'(outQ[0]));
    pop = (expLevel != 0) && ready_i;
    expREn = arst_n_i && en_i && !fifo_empty_i && !rst_i &&
             ((expLevel + int'(pend) - int'(pop)) < 2);
    check("r_en", 32'(fifo_r_en_o), 32'(expREn));
    check("no_overflow", 32'((expLevel + int'(pend)) <= 2), 32'd1);
`ifdef IOB_FIFO2STREAM_LAST_EN
    if (pop) begin
      if (frameIdx == 0) frameLen = (len_i == 0) ? 1 : int'(len_i);
      check("last", 32'(last_o), 32'(frameIdx == frameLen - 1));
      if (last_o) lastCount++;
      frameIdx = (frameIdx == frameLen - 1) ? 0 : frameIdx + 1;
    end else if (expLevel == 0) begin
      check("last_idle", 32'(last_o), 32'd0);
    end
`endif
    rEnSeen = fifo_r_en_o;
    if (rEnSeen) rEnCount++;
    @(posedge clk_i);
    if (pop) begin
      recvQ.push_back(outQ.pop_front());
      popCycles.push_back(cycleNo);
    end
    if (rst_i) begin
      outQ.delete();
      frameIdx = 0;
    end else if (pend) begin
      outQ.push_back(pendVal);
    end
    pend = rEnSeen && !rst_i;
    if (rEnSeen) begin
      pendVal = (fifoQ.size() != 0) ? fifoQ.pop_front() : DATA_W'($urandom);
      if (!pend) sentQ.pop_back();
    end
    cycleNo++;
    #1;
    fifo_r_data_i = pend ? pendVal : DATA_W'($urandom);
  endtask

  task automatic loadWords(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fifoQ.push_back(DATA_W'(base + i));
      sentQ.push_back(DATA_W'(base + i));
    end
  endtask

  // Drain everything with a bounded cycle budget; an expired budget is a failure.
  task automatic drain();
    int budget = 200;
    ready_i = 1'b1;
    en_i = 1'b1;
    forceEmpty = 1'b0;
    while ((fifoQ.size() != 0 || outQ.size() != 0 || pend) && budget > 0) begin
      stepCycle();
      budget--;
    end
    check("drain_budget", 32'(budget > 0), 32'd1);
  endtask

  int startCycle;
  int idx;

  initial begin
    arst_n_i = 1'b0;
    rst_i = 1'b0;
    en_i = 1'b0;
    ready_i = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_r_data_i = '0;
`ifdef IOB_FIFO2STREAM_LAST_EN
    len_i = '0;
`endif
    #2;
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_ren", 32'(fifo_r_en_o), 32'd0);
    @(posedge clk_i); #1;
    arst_n_i = 1'b1;
    stepCycle();

    // Streaming: 8 words, no bubbles, 2-cycle latency.
    $display("[TB] streaming");
    loadWords(8, 1);
    en_i = 1'b1; ready_i = 1'b1;
    popCycles.delete();
    startCycle = cycleNo;
    for (int i = 0; i < 12; i++) stepCycle();
    check("stream_beats", 32'(popCycles.size()), 32'd8);
    if (popCycles.size() == 8) begin
      check("stream_latency", 32'(popCycles[0] - startCycle), 32'd2);
      check("stream_nobubble", 32'(popCycles[7] - popCycles[0]), 32'd7);
    end
    drain();

    // Backpressure after the first word.
    $display("[TB] backpressure");
    loadWords(8, 16'h10);
    popCycles.delete();
    for (int i = 0; i < 3; i++) stepCycle();
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) stepCycle();
    check("bp_level", 32'(level_o), 32'd2);
    check("bp_data", 32'(data_o), 32'h11);
    check("bp_ren", 32'(fifo_r_en_o), 32'd0);
    drain();

    // Empty boundary: a single word.
    $display("[TB] single word");
    rEnCount = 0;
    popCycles.delete();
    loadWords(1, 16'h55);
    for (int i = 0; i < 6; i++) stepCycle();
    check("single_ren", 32'(rEnCount), 32'd1);
    check("single_beats", 32'(popCycles.size()), 32'd1);
    check("single_level", 32'(level_o), 32'd0);

    // en_i falling mid-stream: pending word still arrives.
    $display("[TB] enable drop");
    loadWords(6, 16'h60);
    ready_i = 1'b0;
    stepCycle();
    en_i = 1'b0;
    for (int i = 0; i < 4; i++) stepCycle();
    drain();

    // Synchronous clear mid-operation; in-flight word is discarded.
    $display("[TB] sync clear");
    loadWords(6, 16'h70);
    ready_i = 1'b0;
    for (int i = 0; i < 2; i++) stepCycle();
    rst_i = 1'b1;
    stepCycle();
    rst_i = 1'b0;
    stepCycle();
    check("clr_level", 32'(level_o), 32'd0);
    drain();

    // Asynchronous reset mid-operation.
    $display("[TB] async reset");
    loadWords(6, 16'h80);
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    #2;
    arst_n_i = 1'b0;
    #1;
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_level", 32'(level_o), 32'd0);
    check("arst_data", 32'(data_o), 32'd0);
    check("arst_ren", 32'(fifo_r_en_o), 32'd0);
    outQ.delete();
    if (pend) sentQ.delete(sentQ.size() - fifoQ.size() - 1);
    pend = 1'b0;
    frameIdx = 0;
    stepCycle();
    arst_n_i = 1'b1;
    popCycles.delete();
    ready_i = 1'b1;
    idx = recvQ.size();
    drain();
    check("arst_next", 32'(recvQ[idx]), 32'h82);

`ifdef IOB_FIFO2STREAM_LAST_EN
    $display("[TB] framing");
    lastCount = 0;
    len_i = 16'd3;
    loadWords(7, 16'h90);
    for (int i = 0; i < 12; i++) stepCycle();
    check("len3_lasts", 32'(lastCount), 32'd2);
    drain();
    rst_i = 1'b1; stepCycle(); rst_i = 1'b0;
    lastCount = 0;
    len_i = 16'd0;
    loadWords(5, 16'hA0);
    drain();
    check("len0_lasts", 32'(lastCount), 32'd5);
`endif

    // Random stress: random ready, empty stalls, frame lengths.
    $display("[TB] random stress");
    sentQ.delete();
    recvQ.delete();
    en_i = 1'b1;
    for (int w = 0; w < 10000; w++) begin
      logic [DATA_W-1:0] v = DATA_W'($urandom);
      fifoQ.push_back(v);
      sentQ.push_back(v);
      if (fifoQ.size() >= 4 || w == 9999) begin
        while (fifoQ.size() != 0) begin
          ready_i = ($urandom_range(0, 3) != 0);
          forceEmpty = ($urandom_range(0, 7) == 0);
`ifdef IOB_FIFO2STREAM_LAST_EN
          len_i = LEN_W'($urandom_range(0, 5));
`endif
          stepCycle();
        end
      end
    end
    drain();
    check("stress_count", 32'(recvQ.size()), 32'(sentQ.size()));
    for (int i = 0; i < sentQ.size() && i < recvQ.size(); i++) begin
      if (recvQ[i] !== sentQ[i]) begin
        check("stress_order", 32'(recvQ[i]), 32'(sentQ[i]));
        break;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
